// File: rtl/cpu_isa_pkg.sv
// -----------------------------------------------------------------------------
// cpu_isa_pkg
// Shared ISA definitions: I-type opcodes used by the decoder, the control unit
// and the immediate encoder, the immediate-encoder FSM state type, and a
// helper that packs an I-type instruction word.
// -----------------------------------------------------------------------------
package cpu_isa_pkg;

    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT1 = 2'd1,
        ST_EMIT2 = 2'd2
    } enc_state_t;

    // I-type layout: opcode | rs | rt | imm16
    function automatic logic [31:0] itype(input logic [5:0]  op,
                                          input logic [4:0]  rs,
                                          input logic [4:0]  rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/imm_classify.sv
// -----------------------------------------------------------------------------
// imm_classify
// Purely combinational classifier for the immediate encoder. Picks the shortest
// instruction sequence that rebuilds a 32-bit constant (load mode), or the
// beq/bne word for a branch target (branch mode).
//
// Ports:
//   i_value   constant (load) or branch target (branch)
//   i_mode    0 = load, 1 = branch
//   i_pc      address of the branch instruction (branch mode only)
//   i_rs      branch first source register
//   i_rt      load destination / branch second source register
//   i_bne     branch mode: 0 = beq, 1 = bne
//   o_first   first instruction word
//   o_second  second instruction word (only meaningful when o_two)
//   o_two     request needs two instructions
//   o_ok      request is encodable
// -----------------------------------------------------------------------------
module imm_classify
    import cpu_isa_pkg::*;
(
    input  logic [31:0] i_value,
    input  logic        i_mode,
    input  logic [31:0] i_pc,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic        i_bne,
    output logic [31:0] o_first,
    output logic [31:0] o_second,
    output logic        o_two,
    output logic        o_ok
);

    logic [31:0] w_d;
    logic        w_sext_fits;
    logic        w_hi_zero;
    logic        w_lo_zero;
    logic        w_br_ok;

    // Branch displacement is relative to the delay-slot address.
    assign w_d = i_value - (i_pc + 32'd4);

    // A value survives sign extension from 16 bits when bits 31..15 agree.
    assign w_sext_fits = (i_value[31:15] == {17{i_value[15]}});
    assign w_hi_zero   = (i_value[31:16] == 16'h0000);
    assign w_lo_zero   = (i_value[15:0]  == 16'h0000);

    // Word-aligned and within the signed 18-bit byte range of a 16-bit word offset.
    assign w_br_ok = (w_d[1:0] == 2'b00) && (w_d[31:17] == {15{w_d[17]}});

    always_comb begin
        o_first  = '0;
        o_second = '0;
        o_two    = 1'b0;
        o_ok     = 1'b1;
        if (i_mode) begin
            o_ok    = w_br_ok;
            o_first = itype(i_bne ? OP_BNE : OP_BEQ, i_rs, i_rt, w_d[17:2]);
        end else if (w_sext_fits) begin
            o_first = itype(OP_ADDIU, 5'd0, i_rt, i_value[15:0]);
        end else if (w_hi_zero) begin
            o_first = itype(OP_ORI, 5'd0, i_rt, i_value[15:0]);
        end else if (w_lo_zero) begin
            o_first = itype(OP_LUI, 5'd0, i_rt, i_value[31:16]);
        end else begin
            o_two    = 1'b1;
            o_first  = itype(OP_LUI, 5'd0, i_rt, i_value[31:16]);
            o_second = itype(OP_ORI, i_rt, i_rt, i_value[15:0]);
        end
    end

endmodule

// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
// Sequential immediate encoder: turns a constant load or a branch request into
// one or two MIPS instructions streamed out over a valid/ready interface.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready decodes the state)
//   in_mode, in_bne       0 = load / 1 = branch; beq vs bne
//   in_rs, in_rt          register fields
//   in_value, in_pc       constant or branch target; branch address
//   out_valid / out_ready instruction handshake
//   out_instr, out_last   instruction word; marks final word of a request
//   err                   one-cycle pulse for a dropped unencodable request
// -----------------------------------------------------------------------------
module imm_encoder
    import cpu_isa_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mode,
    input  logic        in_bne,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [31:0] in_value,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        err
);

    enc_state_t  r_state;
    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic        r_out_last;
    logic        r_err;
    logic [31:0] r_second;
    logic        r_two;

    logic [31:0] w_first;
    logic [31:0] w_second;
    logic        w_two;
    logic        w_ok;
    logic        w_accept;

    imm_classify u_classify (
        .i_value  (in_value),
        .i_mode   (in_mode),
        .i_pc     (in_pc),
        .i_rs     (in_rs),
        .i_rt     (in_rt),
        .i_bne    (in_bne),
        .o_first  (w_first),
        .o_second (w_second),
        .o_two    (w_two),
        .o_ok     (w_ok)
    );

    // Gated with reset so no request can appear accepted while the block is held.
    assign in_ready = (r_state == ST_IDLE) && reset;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
            r_second    <= '0;
            r_two       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_ok) begin
                            r_out_valid <= 1'b1;
                            r_out_instr <= w_first;
                            r_out_last  <= !w_two;
                            r_second    <= w_second;
                            r_two       <= w_two;
                            r_state     <= ST_EMIT1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_EMIT1: begin
                    if (out_ready) begin
                        if (r_two) begin
                            // out_valid stays high straight into the second word.
                            r_out_instr <= r_second;
                            r_out_last  <= 1'b1;
                            r_state     <= ST_EMIT2;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_state     <= ST_IDLE;
                        end
                    end
                end
                ST_EMIT2: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_last  = r_out_last;
    assign err       = r_err;

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Sequential immediate encoder: the inverse of the CPU's immediate-extension path. It takes a 32-bit constant (or a branch target) and emits the minimal MIPS instruction sequence whose 16-bit immediates reconstruct that value under the decoder's zero, sign and lui extension rules. The instructions go out over a valid/ready stream. It sits between the test/boot program generator and the instruction-memory write port, and produces `li`-style loads and `beq`/`bne` offsets in hardware.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted on an edge where `in_valid && in_ready`.
- `in_mode`  in  1  0 = constant load, 1 = branch.
- `in_bne`  in  1  branch mode only: 0 = beq, 1 = bne.
- `in_rs`  in  5  branch first source register.
- `in_rt`  in  5  load destination, or branch second source register.
- `in_value`  in  32  constant (load mode) or branch target address (branch mode).
- `in_pc`  in  32  address of the branch instruction; ignored in load mode.
- `out_valid`  out  1  `out_instr` valid.
- `out_ready`  in  1  consumer takes the instruction on an edge where `out_valid && out_ready`.
- `out_instr`  out  32  encoded instruction.
- `out_last`  out  1  high with the final instruction of a request.
- `err`  out  1  one-cycle pulse: the request was unencodable and was dropped.

## Operation
Opcodes: addiu = 0x09, ori = 0x0D, lui = 0x0F, beq = 0x04, bne = 0x05.

Load-mode classification of `in_value` = v. The first matching rule wins:
1. v[31:15] all equal → one instruction, addiu rt,$0,v[15:0] = {0x09, 0, rt, v[15:0]}.
2. v[31:16] == 0 → one instruction, ori rt,$0,v[15:0].
3. v[15:0] == 0 → one instruction, lui rt,v[31:16].
4. Otherwise → two instructions: lui rt,v[31:16], then ori rt,rt,v[15:0] = {0x0D, rt, rt, v[15:0]}.

Load mode never raises `err`. rt = 0 is still encoded as specified.

Branch mode:
- d = in_value − (in_pc + 4), computed modulo 2^32.
- Encodable iff d[1:0] == 0 and d[31:17] all equal.
- If encodable: emit one instruction {op, rs, rt, d[17:2]}, where op is beq or bne per `in_bne`.
- If not encodable: drop the request and pulse `err`.

FSM states: IDLE, EMIT1, EMIT2.
- IDLE:
  - `in_ready = 1` (forced 0 while `reset` is low).
  - On accept with an encodable request: latch the first instruction, plus the second if any, then go to EMIT1.
  - On accept with an unencodable request: `err` = 1 the following cycle and stay in IDLE.
- EMIT1:
  - `out_valid = 1`; `out_last` = 1 unless the request has two instructions.
  - On handshake: go to EMIT2 if two instructions, else IDLE.
- EMIT2:
  - `out_valid = 1`, `out_last = 1`, `out_instr` = the second instruction.
  - On handshake: go to IDLE.
- `in_ready` is 0 in EMIT1 and EMIT2. Input signals are sampled only at accept.

## Timing
- Reset values: state IDLE, `out_valid` 0, `out_instr` 0, `out_last` 0, `err` 0.
- Reset is asynchronous. Asserting it mid-emission abandons the pending instructions immediately, with no partial `out_last`.
- Latency: `out_valid` rises in the cycle after accept. An `err` pulse lasts exactly one cycle after accept.
- Throughput: one request per 2 cycles for a single instruction, per 3 cycles for two, with `out_ready` held at 1.
- Back-pressure: `out_instr` and `out_last` are held stable while `out_valid && !out_ready`.
- `out_valid` never drops without a handshake, except on reset.
- All outputs are registered except `in_ready`, which decodes the state.

## Structure
- Shared package `cpu_isa_pkg` holds:
  - the opcode constants above, also used by the decoder and control unit;
  - the FSM state enum.
- Sub-module `imm_classify`, purely combinational:
  - inputs: value, mode, pc, rs, rt, bne;
  - outputs: first instruction, second instruction, two-instruction flag, encodable flag.
- The top level is FSM plus registers only.

## Test plan
- Load v = 0xFFFF8000, rt = 8 → one instruction 0x24088000, `out_last` = 1.
- Load v = 0x0000ABCD, rt = 9 → 0x3409ABCD. Load v = 0x12340000, rt = 9 → 0x3C091234.
- Load v = 0x12345678, rt = 10, with `out_ready` low for 3 cycles → 0x3C0A1234 is held stable and `out_last` = 0, then 0x354A5678 with `out_last` = 1.
- Branch: pc = 0x100, target = 0xF8, rs = 1, rt = 2, beq → 0x1022FFFD. The same request with bne → 0x1422FFFD.
- Branch: target = 0x102 (misaligned), and separately pc = 0, target = 0x00020004 (out of range) → no `out_valid`, `err` high exactly 1 cycle, `in_ready` back to 1.
- Reset asserted while in EMIT2 → `out_valid` = 0 at once. After release the next request encodes normally.
- Random constant loads → decoding the emitted immediates through zero/sign/lui extension (OR-ing the ori half into the lui result) reproduces v.
